// File: rtl/boothmul_r4.sv
`default_nettype none
// ============================================================================
// Module   : boothmul_r4
// Purpose  : Sequential radix-4 Booth multiplier, signed or unsigned operands,
//            full-width exact product. One Booth digit retired per clock.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk   in   1               rising-edge clock
//   rst_n in   1               synchronous active-low reset
//   arm   in   1               level request, held high for the whole operation
//   uns   in   1               1 = unsigned operands, 0 = two's complement
//   a1    in   A1_LEN          multiplicand (sampled at load)
//   a2    in   A2_LEN          multiplier   (sampled at load)
//   outn  out  A1_LEN+A2_LEN   registered product
//   fin   out  1               registered, high while outn is valid
// Configuration
//   BOOTHMUL_R4_EARLY_EN  when defined, CALC finishes early as soon as the
//                         remaining multiplier digits are all zero.
// ============================================================================
module boothmul_r4 #(
  parameter int A1_LEN = 32,
  parameter int A2_LEN = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arm,
  input  logic                     uns,
  input  logic [A1_LEN-1:0]        a1,
  input  logic [A2_LEN-1:0]        a2,
  output logic [A1_LEN+A2_LEN-1:0] outn,
  output logic                     fin
);

  localparam int ITER = A2_LEN / 2 + 1;
  // Multiplier field: always holds at least one extension bit, so an
  // unsigned operand is never seen as negative by the recoder.
  localparam int MW   = 2 * ITER;
  // Accumulator field: +/-2A plus the geometric tail of earlier partial
  // sums (up to 8/3 |A|) must fit without wrapping.
  localparam int AW   = A1_LEN + 3;
  // P = {accumulator, multiplier, bit below the multiplier}
  localparam int PW   = AW + MW + 1;
  localparam int OW   = A1_LEN + A2_LEN;
  localparam int CW   = $clog2(ITER + 1);

  localparam logic [CW-1:0] C_LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_p;
  logic [AW-1:0]   r_a;
  logic [AW-1:0]   r_neg_a;
  logic [CW-1:0]   r_cnt;

  logic [AW-1:0]   w_a_ext;
  logic [MW-1:0]   w_m_ext;
  logic [AW-1:0]   w_add;
  logic [PW-1:0]   w_sum;
  logic [PW-1:0]   w_step;

  // Operand extension: zero for unsigned, sign for two's complement.
  assign w_a_ext = uns ? {{(AW - A1_LEN){1'b0}}, a1}
                       : {{(AW - A1_LEN){a1[A1_LEN-1]}}, a1};
  assign w_m_ext = uns ? {{(MW - A2_LEN){1'b0}}, a2}
                       : {{(MW - A2_LEN){a2[A2_LEN-1]}}, a2};

  // Booth digit recode from the low three bits of P.
  always_comb begin
    w_add = '0;
    case (r_p[2:0])
      3'b001, 3'b010: w_add = r_a;
      3'b011:         w_add = {r_a[AW-2:0], 1'b0};
      3'b100:         w_add = {r_neg_a[AW-2:0], 1'b0};
      3'b101, 3'b110: w_add = r_neg_a;
      default:        w_add = '0;
    endcase
  end

  // Partial product lands on the accumulator field only.
  assign w_sum  = r_p + {w_add, {(MW + 1){1'b0}}};
  assign w_step = $unsigned($signed(w_sum) >>> 2);

`ifdef BOOTHMUL_R4_EARLY_EN
  logic [CW-1:0]   w_rem;
  logic [PW-1:0]   w_mask;
  logic            w_early;
  logic [PW-1:0]   w_skip;

  assign w_rem = CW'(ITER) - r_cnt;

  // Unconsumed multiplier bits sit in P[2*rem:1]; P[0] is the bit below.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i <= MW; i++) begin
      if (i <= 2 * int'(w_rem)) w_mask[i] = 1'b1;
    end
  end

  // All-equal tail means every remaining digit recodes to zero, so the
  // rest of the operation collapses to a single arithmetic shift.
  assign w_early = ((r_p & w_mask) == '0) || ((r_p & w_mask) == w_mask);
  assign w_skip  = $unsigned($signed(r_p) >>> {w_rem, 1'b0});
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_p     <= '0;
      r_a     <= '0;
      r_neg_a <= '0;
      r_cnt   <= '0;
      outn    <= '0;
      fin     <= 1'b0;
    end else if (!arm) begin
      r_state <= S_IDLE;
      fin     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_p     <= {{AW{1'b0}}, w_m_ext, 1'b0};
          r_a     <= w_a_ext;
          r_neg_a <= -w_a_ext;
          r_cnt   <= '0;
          fin     <= 1'b0;
          r_state <= S_CALC;
        end
        S_CALC: begin
`ifdef BOOTHMUL_R4_EARLY_EN
          if (w_early) begin
            r_p     <= w_skip;
            outn    <= w_skip[OW:1];
            fin     <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_p   <= w_step;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == C_LAST) begin
              outn    <= w_step[OW:1];
              fin     <= 1'b1;
              r_state <= S_DONE;
            end
          end
`else
          r_p   <= w_step;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == C_LAST) begin
            outn    <= w_step[OW:1];
            fin     <= 1'b1;
            r_state <= S_DONE;
          end
`endif
        end
        S_DONE: begin
          fin <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          fin     <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_boothmul_r4.sv
`default_nettype none
// ============================================================================
// Module   : tb_boothmul_r4
// Purpose  : Self-checking bench for boothmul_r4 at 8x8 bits (ITER = 5).
//            Expected products and latencies come from a plain-arithmetic
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_boothmul_r4;

  localparam int L1   = 8;
  localparam int L2   = 8;
  localparam int ITER = L2 / 2 + 1;

  logic              clk;
  logic              rst_n;
  logic              arm;
  logic              uns;
  logic [L1-1:0]     a1;
  logic [L2-1:0]     a2;
  logic [L1+L2-1:0]  outn;
  logic              fin;

  int n_tests;
  int n_fail;

  boothmul_r4 #(.A1_LEN(L1), .A2_LEN(L2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arm   (arm),
    .uns   (uns),
    .a1    (a1),
    .a2    (a2),
    .outn  (outn),
    .fin   (fin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact product, truncated to the 16-bit output (never overflows).
  function automatic logic [15:0] ref_prod(input logic [7:0] x, input logic [7:0] y,
                                           input logic u);
    longint sx, sy, pr;
    logic [63:0] pv;
    sx = u ? longint'({56'd0, x}) : longint'($signed(x));
    sy = u ? longint'({56'd0, y}) : longint'($signed(y));
    pr = sx * sy;
    pv = pr;
    return pv[15:0];
  endfunction

  // Edges from the load edge (edge 1) until fin is seen high.
  function automatic int ref_lat(input logic [7:0] y, input logic u);
`ifdef BOOTHMUL_R4_EARLY_EN
    logic [2*ITER:0] t;
    logic            same;
    // t[0] is the implicit zero below the LSB; t[j] = extended multiplier bit j-1.
    t = u ? {3'b000, y, 1'b0} : {{3{y[7]}}, y, 1'b0};
    for (int k = 0; k < ITER; k++) begin
      same = 1'b1;
      for (int j = 2 * k; j <= 2 * ITER; j++) begin
        if (t[j] != t[2 * k]) same = 1'b0;
      end
      if (same) return k + 2;
    end
    return ITER + 1;
`else
    if (u && y == 8'd0) return ITER + 1;  // latency is data-independent
    return ITER + 1;
`endif
  endfunction

  // Runs one complete operation; the operands are scrambled right after the
  // load edge, the product is re-read one edge later, then arm is dropped.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic u,
                        output logic [15:0] p, output int lat,
                        output logic [15:0] p_hold, output logic f_drop);
    @(negedge clk);
    a1 = x; a2 = y; uns = u; arm = 1'b1;
    lat = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        a1  = 8'($urandom);
        a2  = 8'($urandom);
        uns = 1'($urandom);
      end
      if (fin) begin
        lat = e;
        break;
      end
    end
    p = outn;
    @(posedge clk); #1;
    p_hold = outn;
    arm = 1'b0;
    @(posedge clk); #1;
    f_drop = fin;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; arm = 1'b0; uns = 1'b0; a1 = '0; a2 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (fin !== 1'b0) begin n_fail++; $display("FAIL reset_fin got %b want 0", fin); end
    n_tests++;
    if (outn !== 16'h0) begin n_fail++; $display("FAIL reset_outn got %h want 0000", outn); end
    // Reset must win over arm.
    @(negedge clk); arm = 1'b1; a1 = 8'h11; a2 = 8'h22;
    repeat (ITER + 3) @(posedge clk);
    #1;
    n_tests++;
    if (fin !== 1'b0) begin n_fail++; $display("FAIL reset_prio_fin got %b want 0", fin); end
    @(negedge clk); arm = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [7:0]  xs [3];
    logic [7:0]  ys [3];
    logic        us [3];
    logic [15:0] want [3];
    logic [15:0] p, ph;
    logic        fd;
    int          lat;
    xs = '{8'hF9, 8'h80, 8'hFF};
    ys = '{8'h03, 8'h80, 8'hFF};
    us = '{1'b0, 1'b0, 1'b1};
    want = '{16'hFFEB, 16'h4000, 16'hFE01};
    for (int i = 0; i < 3; i++) begin
      run_op(xs[i], ys[i], us[i], p, lat, ph, fd);
      n_tests++;
      if (p !== want[i]) begin
        n_fail++; $display("FAIL dir%0d_prod got %h want %h", i, p, want[i]);
      end
      n_tests++;
      if (p !== ref_prod(xs[i], ys[i], us[i])) begin
        n_fail++; $display("FAIL dir%0d_model got %h want %h", i, p, ref_prod(xs[i], ys[i], us[i]));
      end
      n_tests++;
      if (lat !== ref_lat(ys[i], us[i])) begin
        n_fail++; $display("FAIL dir%0d_lat got %0d want %0d", i, lat, ref_lat(ys[i], us[i]));
      end
      n_tests++;
      if (ph !== want[i]) begin
        n_fail++; $display("FAIL dir%0d_hold got %h want %h", i, ph, want[i]);
      end
      n_tests++;
      if (fd !== 1'b0) begin
        n_fail++; $display("FAIL dir%0d_drop_fin got %b want 0", i, fd);
      end
    end
  endtask

  task automatic test_abort;
    logic [15:0] p, ph;
    logic        fd;
    int          lat;
    @(negedge clk);
    a1 = 8'h33; a2 = 8'h44; uns = 1'b0; arm = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    arm = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (fin !== 1'b0) begin n_fail++; $display("FAIL abort_fin got %b want 0", fin); end
    run_op(8'h05, 8'hFE, 1'b0, p, lat, ph, fd);
    n_tests++;
    if (p !== 16'hFFF6) begin n_fail++; $display("FAIL abort_rearm_prod got %h want FFF6", p); end
    n_tests++;
    if (lat !== ref_lat(8'hFE, 1'b0)) begin
      n_fail++; $display("FAIL abort_rearm_lat got %0d want %0d", lat, ref_lat(8'hFE, 1'b0));
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] p, ph;
    logic        fd;
    int          lat;
    @(negedge clk);
    a1 = 8'h12; a2 = 8'h34; uns = 1'b0; arm = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (fin !== 1'b0) begin n_fail++; $display("FAIL midrst_fin got %b want 0", fin); end
    n_tests++;
    if (outn !== 16'h0) begin n_fail++; $display("FAIL midrst_outn got %h want 0000", outn); end
    @(negedge clk); rst_n = 1'b1; arm = 1'b0;
    run_op(8'h9C, 8'h37, 1'b0, p, lat, ph, fd);
    n_tests++;
    if (p !== ref_prod(8'h9C, 8'h37, 1'b0)) begin
      n_fail++; $display("FAIL midrst_prod got %h want %h", p, ref_prod(8'h9C, 8'h37, 1'b0));
    end
    n_tests++;
    if (lat !== ITER + 1) begin n_fail++; $display("FAIL midrst_lat got %0d want %0d", lat, ITER + 1); end
  endtask

  task automatic test_zero_mult;
    logic [15:0] p, ph;
    logic        fd;
    int          lat;
    int          want_lat;
`ifdef BOOTHMUL_R4_EARLY_EN
    want_lat = 2;
`else
    want_lat = ITER + 1;
`endif
    run_op(8'h7F, 8'h00, 1'b0, p, lat, ph, fd);
    n_tests++;
    if (p !== 16'h0000) begin n_fail++; $display("FAIL zero_prod got %h want 0000", p); end
    n_tests++;
    if (lat !== want_lat) begin n_fail++; $display("FAIL zero_lat got %0d want %0d", lat, want_lat); end
  endtask

  task automatic test_random;
    logic [7:0]  x, y;
    logic        u;
    logic [15:0] p, ph;
    logic        fd;
    int          lat;
    for (int i = 0; i < 2500; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      u = 1'($urandom);
      if (i % 16 == 0) y = (i % 32 == 0) ? 8'h00 : 8'hFF;
      run_op(x, y, u, p, lat, ph, fd);
      n_tests++;
      if (p !== ref_prod(x, y, u)) begin
        n_fail++;
        $display("FAIL rand_prod a1=%h a2=%h uns=%b got %h want %h", x, y, u, p, ref_prod(x, y, u));
      end
      n_tests++;
      if (lat !== ref_lat(y, u)) begin
        n_fail++;
        $display("FAIL rand_lat a2=%h uns=%b got %0d want %0d", y, u, lat, ref_lat(y, u));
      end
      n_tests++;
      if (ph !== p || fd !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_hold got %h/%b want %h/0", ph, fd, p);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_directed();
    test_abort();
    test_reset_mid();
    test_zero_mult();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
